divide_10by5_seq: RTL and testbench

DIVIDE_10BY5_SEQ -- requirements
Module: divide_10by5_seq

---
 rtl/divide_10by5_seq.sv | 117 +++++++++++
 tb/tb_divide_10by5_seq.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/divide_10by5_seq.sv
// Sequential 10-bit by 5-bit unsigned restoring divider, one quotient bit per cycle.
// Divide by zero skips the iterations and reports an all-ones quotient.
module divide_10by5_seq (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [9:0] dividend,
  input  logic [4:0] divisor,
  output logic [9:0] quotient,
  output logic [4:0] remainder,
  output logic       busy,
  output logic       done,
  output logic       div_by_zero
);

  localparam int unsigned DW = 10;
  localparam int unsigned VW = 5;
  localparam int unsigned PW = 6;
  localparam int unsigned CW = 4;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  state_t        state, state_next;
  logic [DW-1:0] dvd, dvd_next;
  logic [VW-1:0] dvs, dvs_next;
  logic [PW-1:0] part, part_next;
  logic [CW-1:0] cnt, cnt_next;
  logic [DW-1:0] quotient_next;
  logic [VW-1:0] remainder_next;
  logic          dbz_next;
  logic          busy_next;
  logic          done_next;
  logic [PW-1:0] trial;
  logic          qbit;

  // The dividend register shifts out numerator bits MSB first and shifts in quotient bits.
  always_comb begin
    state_next     = state;
    dvd_next       = dvd;
    dvs_next       = dvs;
    part_next      = part;
    cnt_next       = cnt;
    quotient_next  = quotient;
    remainder_next = remainder;
    dbz_next       = div_by_zero;
    trial          = {part[VW-1:0], dvd[DW-1]};
    qbit           = (trial >= {1'b0, dvs});

    case (state)
      IDLE, DONE: begin
        if (start) begin
          dvd_next  = dividend;
          dvs_next  = divisor;
          part_next = '0;
          cnt_next  = '0;
          dbz_next  = 1'b0;
          if (divisor == '0) begin
            state_next     = DONE;
            quotient_next  = '1;
            remainder_next = '0;
            dbz_next       = 1'b1;
          end else begin
            state_next = CALC;
          end
        end else begin
          state_next = IDLE;
        end
      end
      CALC: begin
        part_next = qbit ? (trial - PW'(dvs)) : trial;
        dvd_next  = {dvd[DW-2:0], qbit};
        cnt_next  = cnt + CW'(1);
        if (cnt == CW'(DW - 1)) begin
          state_next     = DONE;
          quotient_next  = dvd_next;
          remainder_next = part_next[VW-1:0];
        end
      end
      default: state_next = IDLE;
    endcase

    busy_next = (state_next == CALC);
    done_next = (state_next == DONE);
  end

  // State and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      dvd         <= '0;
      dvs         <= '0;
      part        <= '0;
      cnt         <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      state       <= state_next;
      dvd         <= dvd_next;
      dvs         <= dvs_next;
      part        <= part_next;
      cnt         <= cnt_next;
      quotient    <= quotient_next;
      remainder   <= remainder_next;
      div_by_zero <= dbz_next;
      busy        <= busy_next;
      done        <= done_next;
    end
  end

endmodule

// File: tb/tb_divide_10by5_seq.sv
// Randomized self-checking bench for divide_10by5_seq against an arithmetic reference.
`timescale 1ns/1ps
module tb_divide_10by5_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [9:0] dividend;
  logic [4:0] divisor;
  logic [9:0] quotient;
  logic [4:0] remainder;
  logic       busy;
  logic       done;
  logic       div_by_zero;

  int checks = 0;
  int errors = 0;

  divide_10by5_seq dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .dividend   (dividend),
    .divisor    (divisor),
    .quotient   (quotient),
    .remainder  (remainder),
    .busy       (busy),
    .done       (done),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Called at a negedge; start is sampled at the following posedge. Returns in the
  // negedge where done is observed (inputs left with start=0). inj>0 pulses a
  // conflicting start at that many cycles into the operation.
  task automatic run_div(input string tag, input int a, input int b, input int inj);
    int lat;
    int busy_cnt;
    int exp_q;
    int exp_r;
    int exp_lat;
    dividend = 10'(a);
    divisor  = 5'(b);
    start    = 1'b1;
    if (b == 0) begin
      exp_q = 1023; exp_r = 0; exp_lat = 1;
    end else begin
      exp_q = a / b; exp_r = a % b; exp_lat = 11;
    end
    @(negedge clk);
    lat      = 1;
    busy_cnt = 0;
    while (!done && lat < 20) begin
      busy_cnt += int'(busy);
      if (lat == 1 || lat != inj) begin
        start    = 1'b0;
        dividend = 10'($urandom);
        divisor  = 5'($urandom);
      end
      if (lat == inj) begin
        start    = 1'b1;
        dividend = 10'd32;
        divisor  = 5'd8;
      end
      @(negedge clk);
      lat++;
    end
    start = 1'b0;
    check({tag, " done_seen"}, int'(done), 1);
    check({tag, " latency"}, lat, exp_lat);
    check({tag, " busy_cycles"}, busy_cnt, exp_lat - 1);
    check({tag, " busy_in_done"}, int'(busy), 0);
    check({tag, " quotient"}, int'(quotient), exp_q);
    check({tag, " remainder"}, int'(remainder), exp_r);
    check({tag, " div_by_zero"}, int'(div_by_zero), (b == 0) ? 1 : 0);
  endtask

  // From the done cycle, let one idle cycle pass and confirm the pulse ended and results held.
  task automatic idle_after(input string tag);
    int q0;
    int r0;
    q0 = int'(quotient);
    r0 = int'(remainder);
    @(negedge clk);
    check({tag, " done_pulse_single"}, int'(done), 0);
    check({tag, " idle_busy"}, int'(busy), 0);
    check({tag, " hold_q"}, int'(quotient), q0);
    check({tag, " hold_r"}, int'(remainder), r0);
  endtask

  initial begin
    rst      = 1'b1;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    #2;
    check("reset quotient", int'(quotient), 0);
    check("reset remainder", int'(remainder), 0);
    check("reset busy", int'(busy), 0);
    check("reset done", int'(done), 0);
    check("reset dbz", int'(div_by_zero), 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    run_div("s1 961/31", 961, 31, 0);   idle_after("s1");
    run_div("s2 200/7", 200, 7, 0);     idle_after("s2a");
    run_div("s2 1023/31", 1023, 31, 0); idle_after("s2b");
    run_div("s3 5/0", 5, 0, 0);         idle_after("s3");
    run_div("s4 3/13", 3, 13, 0);
    run_div("s4 156/13 b2b", 156, 13, 0); idle_after("s4");
    run_div("s5 ignore", 700, 9, 4);    idle_after("s5");
    run_div("edge 0/1", 0, 1, 0);       idle_after("e0");
    run_div("edge 1023/1", 1023, 1, 0); idle_after("e1");
    run_div("dbz b2b", 77, 0, 0);
    run_div("after dbz b2b", 77, 5, 0); idle_after("e2");

    // Reset mid-calculation aborts the division asynchronously.
    dividend = 10'd500; divisor = 5'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    check("s6 busy before rst", int'(busy), 1);
    #2 rst = 1'b1;
    #1;
    check("s6 async busy", int'(busy), 0);
    check("s6 async quotient", int'(quotient), 0);
    check("s6 async remainder", int'(remainder), 0);
    check("s6 async dbz", int'(div_by_zero), 0);
    begin
      int seen = 0;
      repeat (2) begin @(negedge clk); seen += int'(done); end
      rst = 1'b0;
      repeat (14) begin @(negedge clk); seen += int'(done) + int'(busy); end
      check("s6 no done after abort", seen, 0);
    end
    run_div("s6 32/8", 32, 8, 0); idle_after("s6");

    // Randomized sequence with mixed idle gaps and back-to-back starts.
    for (int i = 0; i < 40; i++) begin
      int a;
      int b;
      a = int'($urandom_range(0, 1023));
      b = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 31));
      if (i % 5 == 0) a = int'($urandom_range(0, 31));
      run_div($sformatf("rnd%0d %0d/%0d", i, a, b), a, b, 0);
      if ($urandom_range(0, 1) == 1) idle_after($sformatf("rnd%0d", i));
    end
    idle_after("final");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
